imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Byte-stream writer that fills the byte-addressed instruction memory through its write port before the core runs. It accepts bytes over a valid/ready handshake and assembles them into little-endian 32-bit words. Each completed word is written at consecutive word addresses from 0. While loading, it holds the core (PC write and pipeline) frozen through core_hold. It sits between the off-chip/testbench byte source and the instruction memory write port, in front of the IF stage.

Parameters:
IMEM_BYTES, 128, instruction memory size in bytes; must match the PC address mask of 0x7F.
LEN_W, 6, width of load_words and words_loaded; must hold IMEM_BYTES/4 (32).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
load_start  input  1  single-cycle request to begin a load; honoured only in IDLE.
load_words  input  LEN_W  number of 32-bit words to load; sampled with load_start.
byte_valid  input  1  byte_data is valid.
byte_data  input  8  next program byte, lowest address first.
byte_ready  output  1  loader accepts a byte this cycle.
imem_we  output  1  instruction memory write enable, one cycle per word.
imem_addr  output  32  byte address of the word written; bits [31:7] always 0, bits [1:0] always 0.
imem_wdata  output  32  assembled word, first byte received in [7:0].
core_hold  output  1  high while a load is in progress; the core must not advance the PC.
load_done  output  1  one-cycle pulse when a load completes.
load_err  output  1  sticky error for a rejected length; cleared by the next accepted load_start or by reset.
words_loaded  output  LEN_W  count of words written in the current or last load.

Behaviour:
- Reset (synchronous): state IDLE. All outputs 0: byte_ready, imem_we, imem_addr, imem_wdata, core_hold, load_done, load_err, words_loaded. The assembly register and byte counter are also cleared.
- States: IDLE, RECV, WRITE, DONE.
- IDLE: byte_ready = 0. On load_start:
  - load_words == 0: go to DONE. No writes.
  - load_words > IMEM_BYTES/4: set load_err and stay in IDLE. core_hold stays 0.
  - Otherwise: clear load_err and words_loaded, set byte_cnt = 0, go to RECV.
- RECV: byte_ready = 1 and core_hold = 1. A byte transfers on byte_valid & byte_ready.
  - Byte k (k = 0..3) of a word is placed in lanes [8k+7:8k].
  - On the 4th byte, go to WRITE.
  - With no byte_valid, the loader waits indefinitely.
- WRITE (exactly 1 cycle): imem_we = 1, imem_addr = words_loaded*4, imem_wdata = assembled word, byte_ready = 0.
  - Next cycle words_loaded increments.
  - If the new count equals load_words, go to DONE; otherwise return to RECV with byte_cnt = 0.
- DONE (1 cycle): load_done = 1, core_hold = 1, then go to IDLE. core_hold is 0 from the first IDLE cycle.
- core_hold is high from the cycle after an accepted load_start through the DONE cycle. For a zero-length load it is high in DONE only.
- Throughput: at least 5 cycles per word (4 byte cycles + 1 write cycle).
- load_start outside IDLE is ignored. load_words is only sampled in IDLE.
- Bytes presented in IDLE, WRITE or DONE are not accepted; the source holds them.
- Address arithmetic is modulo IMEM_BYTES. The length check guarantees no wrap within a legal load.
- Reset mid-load: return to IDLE immediately and discard the partial word. Words already written stay in memory. core_hold drops on the cycle after reset.

Decomposition:
- Package imem_loader_pkg:
  - state enum (IDLE, RECV, WRITE, DONE);
  - IMEM_BYTES default;
  - WORD_BYTES = 4;
  - IMEM_ADDR_MASK = 32'h0000007F.
- Sub-module byte_assembler:
  - holds the 2-bit byte counter and the 32-bit lane register;
  - inputs: clk, reset, clear, byte_en, byte_data;
  - outputs: word, word_full.
- The top level contains the FSM, words_loaded and the output registers.

Test Plan:
1. Reset held 2 cycles, then released -> all outputs 0, byte_ready 0, and bytes offered with byte_valid=1 are not taken.
2. load_start, load_words=1, bytes 03,21,40,01 back-to-back -> one imem_we with addr 0x00, wdata 0x01402103. Then a load_done pulse, words_loaded=1, and core_hold high for 6 cycles.
3. load_words=4, bytes 03 21 40 01 93 01 10 01 13 82 31 00 93 82 31 00, with byte_valid randomly deasserted -> writes in order:
   - addr 0x0: 0x01402103
   - addr 0x4: 0x01100193
   - addr 0x8: 0x00318213
   - addr 0xC: 0x00318293
   Then load_done, and core_hold falls the cycle after load_done.
4. load_words=33 -> load_err=1, no imem_we, core_hold 0. Then load_words=0 -> load_err clears, load_done pulses one cycle later, no writes.
5. load_words=2, reset asserted after the 6th byte -> exactly one write (addr 0). All outputs 0 after reset. A following 1-word load writes at addr 0 correctly.
6. load_start re-pulsed with load_words=5 during RECV of a 2-word load -> ignored. Exactly 2 writes occur, words_loaded=2.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_t;

  localparam int unsigned DEFAULT_IMEM_BYTES = 128;
  localparam int unsigned WORD_BYTES         = 4;
  localparam logic [31:0] IMEM_ADDR_MASK     = 32'h0000_007F;

  // Byte address of a word index, wrapped to the instruction memory size.
  function automatic logic [31:0] word_byte_addr(input logic [29:0] idx);
    return {idx, 2'b00} & IMEM_ADDR_MASK;
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs incoming bytes little-endian into a 32-bit word; byte k lands in lane k.
module byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt  <= '0;
      word <= '0;
    end else if (byte_en) begin
      word[{cnt, 3'b000} +: 8] <= byte_data;
      cnt                      <= cnt + 2'd1;
    end
  end

  // High while the byte that completes the word is being taken.
  assign word_full = byte_en && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory as consecutive words from address 0, holding the core meanwhile.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = DEFAULT_IMEM_BYTES,
  parameter int unsigned LEN_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic [LEN_W-1:0] load_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             core_hold,
  output logic             load_done,
  output logic             load_err,
  output logic [LEN_W-1:0] words_loaded
);

  localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(IMEM_BYTES / WORD_BYTES);

  state_t           state, state_next;
  logic [LEN_W-1:0] len_q;
  logic [31:0]      word;
  logic             word_full;
  logic             start_ok, start_bad, byte_en, asm_clear, last_word;

  assign start_ok  = (state == IDLE) && load_start && (load_words <= MAX_WORDS);
  assign start_bad = (state == IDLE) && load_start && (load_words > MAX_WORDS);
  assign byte_en   = byte_valid && (state == RECV);
  assign asm_clear = start_ok || (state == WRITE);
  assign last_word = (words_loaded + LEN_W'(1)) == len_q;

  byte_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .byte_en   (byte_en),
    .byte_data (byte_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start_ok) state_next = (load_words == '0) ? DONE : RECV;
      end
      RECV:  if (word_full) state_next = WRITE;
      WRITE: state_next = last_word ? DONE : RECV;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = (state == RECV);
    imem_we    = (state == WRITE);
    core_hold  = (state != IDLE);
    load_done  = (state == DONE);
    imem_addr  = '0;
    imem_wdata = '0;
    if (state == WRITE) begin
      imem_addr  = word_byte_addr(30'(words_loaded));
      imem_wdata = word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q        <= '0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      if (start_ok) begin
        len_q        <= load_words;
        load_err     <= 1'b0;
        words_loaded <= '0;
      end else if (start_bad) begin
        load_err <= 1'b1;
      end
      if (state == WRITE) words_loaded <= words_loaded + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a word-list memory model built from the program bytes.
module tb_imem_loader;

  localparam int unsigned LEN_W = 6;

  logic             clk = 1'b0;
  logic             reset, load_start, byte_valid;
  logic [LEN_W-1:0] load_words;
  logic [7:0]       byte_data;
  logic             byte_ready, imem_we, core_hold, load_done, load_err;
  logic [31:0]      imem_addr, imem_wdata;
  logic [LEN_W-1:0] words_loaded;

  imem_loader #(.IMEM_BYTES(128), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .load_words   (load_words),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  prog [128];
  logic [31:0] model_mem [32];
  logic [31:0] dut_mem [32];
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int          hold_cyc, stall_cyc, fires;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      dut_mem[imem_addr[6:2]] = imem_wdata;
    end
    if (core_hold) hold_cyc++;
    if (byte_ready && !byte_valid) stall_cyc++;
    if (byte_ready && byte_valid) fires++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] ref_word(input int i);
    return {prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]};
  endfunction

  task automatic fill_prog();
    for (int i = 0; i < 128; i++) prog[i] = 8'($urandom);
  endtask

  task automatic start_load(input int n);
    load_start = 1'b1;
    load_words = LEN_W'(n);
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_bytes(input int first, input int n, input bit gaps);
    int idx    = first;
    int budget = n * 20 + 50;
    bit fire;
    while (idx < first + n) begin
      if (budget == 0) begin
        check("byte_timeout", 32'(idx), 32'(first + n));
        break;
      end
      budget--;
      byte_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      byte_data  = prog[idx];
      @(negedge clk);
      fire = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (fire) idx++;
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    repeat (budget) begin
      @(negedge clk);
      if (load_done) break;
    end
    check("done_seen", 32'(load_done), 32'd1);
  endtask

  task automatic check_writes(input int n, input string tag);
    check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check({tag, "_addr"}, wr_addr[i], 32'((i * 4) & 32'h7F));
      check({tag, "_data"}, wr_data[i], ref_word(i));
    end
    for (int i = 0; i < n; i++) model_mem[i] = ref_word(i);
  endtask

  task automatic do_load(input int n, input bit gaps, input string tag);
    wr_addr.delete();
    wr_data.delete();
    hold_cyc  = 0;
    stall_cyc = 0;
    start_load(n);
    send_bytes(0, 4 * n, gaps);
    wait_done(60);
    check({tag, "_hold_in_done"}, 32'(core_hold), 32'd1);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'(n));
    @(negedge clk);
    check({tag, "_hold_drop"}, 32'(core_hold), 32'd0);
    check({tag, "_done_pulse"}, 32'(load_done), 32'd0);
    check({tag, "_hold_cycles"}, 32'(hold_cyc - stall_cyc), 32'(5 * n + 1));
    check_writes(n, tag);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_addr"}, imem_addr, 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_hold"}, 32'(core_hold), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_err"}, 32'(load_err), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  logic [7:0]  t3_bytes [16] = '{8'h03, 8'h21, 8'h40, 8'h01, 8'h93, 8'h01, 8'h10, 8'h01,
                                  8'h13, 8'h82, 8'h31, 8'h00, 8'h93, 8'h82, 8'h31, 8'h00};
  logic [31:0] t3_words [4]  = '{32'h01402103, 32'h01100193, 32'h00318213, 32'h00318293};

  initial begin
    reset      = 1'b1;
    load_start = 1'b0;
    load_words = '0;
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    for (int i = 0; i < 32; i++) begin
      model_mem[i] = '0;
      dut_mem[i]   = '0;
    end

    // 1: reset, then bytes offered in IDLE are refused
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    fires = 0;
    @(negedge clk);
    check_idle_outputs("t1");
    repeat (3) @(negedge clk);
    check("t1_no_accept", 32'(fires), 32'd0);
    byte_valid = 1'b0;

    // 2: single word, back-to-back bytes
    for (int i = 0; i < 4; i++) prog[i] = t3_bytes[i];
    do_load(1, 1'b0, "t2");
    check("t2_hold6", 32'(hold_cyc), 32'd6);

    // 3: four words with random valid gaps
    for (int i = 0; i < 16; i++) prog[i] = t3_bytes[i];
    do_load(4, 1'b1, "t3");
    for (int i = 0; i < 4; i++) check("t3_const", wr_data[i], t3_words[i]);

    // 4: oversize length rejected, zero length completes without writes
    wr_addr.delete();
    wr_data.delete();
    start_load(33);
    @(negedge clk);
    check("t4_err_set", 32'(load_err), 32'd1);
    check("t4_hold_low", 32'(core_hold), 32'd0);
    repeat (3) @(negedge clk);
    check("t4_err_sticky", 32'(load_err), 32'd1);
    check("t4_no_writes", 32'(wr_addr.size()), 32'd0);
    start_load(0);
    @(negedge clk);
    check("t4_err_clear", 32'(load_err), 32'd0);
    check("t4_zero_done", 32'(load_done), 32'd1);
    check("t4_zero_hold", 32'(core_hold), 32'd1);
    @(negedge clk);
    check("t4_done_end", 32'(load_done), 32'd0);
    check("t4_hold_end", 32'(core_hold), 32'd0);
    check("t4_zero_words", 32'(words_loaded), 32'd0);
    check("t4_zero_writes", 32'(wr_addr.size()), 32'd0);

    // 5: reset after the 6th byte of a 2-word load
    fill_prog();
    wr_addr.delete();
    wr_data.delete();
    start_load(2);
    send_bytes(0, 6, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("t5_rst");
    check_writes(1, "t5");
    fill_prog();
    do_load(1, 1'b0, "t5b");

    // 6: load_start during RECV is ignored
    fill_prog();
    wr_addr.delete();
    wr_data.delete();
    start_load(2);
    send_bytes(0, 2, 1'b0);
    start_load(5);
    send_bytes(2, 6, 1'b1);
    wait_done(60);
    check("t6_words", 32'(words_loaded), 32'd2);
    @(negedge clk);
    check_writes(2, "t6");

    // random loads, including the full-memory boundary
    for (int r = 0; r < 6; r++) begin
      fill_prog();
      do_load((r == 0) ? 32 : int'($urandom_range(1, 8)), 1'b1, "rnd");
    end
    for (int i = 0; i < 32; i++) check("mem", dut_mem[i], model_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
